// File: rtl/addr_gen_upd_param.sv
// addr_gen_upd_param
// Read-address generator for the LSTM update-parameter stage. It walks the
// gate-delta buffer (d) and the matching operand buffer (X, H or none for
// bias) so the MAC array can accumulate dW, dU or db over T timesteps.
// Loop order: cell c (outer), operand i (middle), timestep t (inner). Each
// (c, i) pair is one accumulation run of T addresses.
//
// Ports:
//   clk, rst (sync, active low), en (0 freezes everything)
//   i_start, i_mode (0 X, 1 H, 2 bias, 3 reserved), i_timestep (T)
//   o_addr_d, o_addr_x   address pair
//   o_valid, o_zero, o_last  per-address flags
//   o_busy, o_done       sequence status
//   o_state              current FSM state (debug)
//
// Handshake: i_start is sampled only in IDLE on an en=1 edge; a legal request
// (T in 1..MAX_TIMESTEP, mode != 3) raises o_busy from the next cycle.
// o_valid qualifies o_addr_d/o_addr_x/o_zero/o_last for exactly one
// consumer cycle; there is no back-pressure other than en. o_done pulses for
// one cycle after the final address, and o_busy drops the cycle after that.
module addr_gen_upd_param #(
  parameter int ADDR_WIDTH   = 12,
  parameter int TS_WIDTH     = 4,
  parameter int MAX_TIMESTEP = 15,
  parameter int NUM_CELL     = 8,
  parameter int NUM_INPUT    = 8,
  parameter int DELAY        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [TS_WIDTH-1:0]   i_timestep,
  output logic [ADDR_WIDTH-1:0] o_addr_d,
  output logic [ADDR_WIDTH-1:0] o_addr_x,
  output logic                  o_valid,
  output logic                  o_zero,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_state
);

  localparam int CMAX = (NUM_CELL > NUM_INPUT) ? NUM_CELL : NUM_INPUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int GW   = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int AW   = ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  state_t                r_state, w_state;
  logic [TS_WIDTH-1:0]   r_tmax, w_tmax;
  logic [1:0]            r_mode, w_mode;
  logic [TS_WIDTH-1:0]   r_t, w_t;
  logic [CW-1:0]         r_i, w_i;
  logic [CW-1:0]         r_c, w_c;
  logic [GW-1:0]         r_gap, w_gap;
  logic [AW-1:0]         r_addr_d, w_addr_d;
  logic [AW-1:0]         r_addr_x, w_addr_x;
  logic                  r_zero, w_zero;
  logic                  r_last, w_last;
  logic                  r_valid, w_valid;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;

  logic                  w_is_x, w_is_h;
  logic [CW-1:0]         w_nin_m1;
  logic                  w_final_run;
  logic                  w_start_ok;
  logic [TS_WIDTH-1:0]   w_n_t;
  logic [CW-1:0]         w_n_i, w_n_c;
  logic [AW-1:0]         w_n_addr_d, w_n_addr_x;
  logic                  w_n_zero, w_n_last;

  assign w_is_x = (r_mode == 2'd0);
  assign w_is_h = (r_mode == 2'd1);

  always_comb begin
    w_nin_m1 = '0;
    case (r_mode)
      2'd0:    w_nin_m1 = CW'(NUM_INPUT - 1);
      2'd1:    w_nin_m1 = CW'(NUM_CELL - 1);
      default: w_nin_m1 = '0;
    endcase
  end

  assign w_final_run = (r_i == w_nin_m1) && (r_c == CW'(NUM_CELL - 1));
  assign w_start_ok  = i_start && (i_timestep != '0) &&
                       (32'(i_timestep) <= MAX_TIMESTEP) && (i_mode != 2'd3);

  // Position following the current one. Addresses advance by stride only:
  // d steps by NUM_CELL per timestep and restarts at c for each new run.
  always_comb begin
    w_n_t      = r_t + 1'b1;
    w_n_i      = r_i;
    w_n_c      = r_c;
    w_n_addr_d = r_addr_d + AW'(NUM_CELL);
    w_n_addr_x = '0;
    w_n_zero   = 1'b0;
    if (w_is_x) begin
      w_n_addr_x = r_addr_x + AW'(NUM_INPUT);
    end else if (w_is_h) begin
      // t=0 presented the implicit h[-1]; real H rows start at row 0 for t=1.
      w_n_addr_x = (r_t == '0) ? AW'(r_i) : r_addr_x + AW'(NUM_CELL);
    end
    if (r_t == r_tmax) begin
      w_n_t      = '0;
      w_n_zero   = w_is_h;
      w_n_addr_x = '0;
      if (r_i != w_nin_m1) begin
        w_n_i      = r_i + 1'b1;
        w_n_addr_d = AW'(r_c);
        if (w_is_x) w_n_addr_x = AW'(r_i) + 1'b1;
      end else begin
        w_n_i      = '0;
        w_n_c      = r_c + 1'b1;
        w_n_addr_d = AW'(r_c) + 1'b1;
      end
    end
    w_n_last = (w_n_t == r_tmax);
  end

  always_comb begin
    w_state  = r_state;
    w_tmax   = r_tmax;
    w_mode   = r_mode;
    w_t      = r_t;
    w_i      = r_i;
    w_c      = r_c;
    w_gap    = r_gap;
    w_addr_d = r_addr_d;
    w_addr_x = r_addr_x;
    w_zero   = r_zero;
    w_last   = r_last;
    w_valid  = r_valid;
    w_busy   = r_busy;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_valid = 1'b0;
        w_busy  = 1'b0;
        if (w_start_ok) begin
          w_state  = S_RUN;
          w_tmax   = i_timestep - 1'b1;
          w_mode   = i_mode;
          w_t      = '0;
          w_i      = '0;
          w_c      = '0;
          w_addr_d = '0;
          w_addr_x = '0;
          w_zero   = (i_mode == 2'd1);
          w_last   = (i_timestep == TS_WIDTH'(1));
          w_valid  = 1'b1;
          w_busy   = 1'b1;
        end
      end
      S_RUN: begin
        if (r_last && w_final_run) begin
          w_state = S_DONE;
          w_valid = 1'b0;
          w_zero  = 1'b0;
          w_last  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_t      = w_n_t;
          w_i      = w_n_i;
          w_c      = w_n_c;
          w_addr_d = w_n_addr_d;
          w_addr_x = w_n_addr_x;
          w_zero   = w_n_zero;
          w_last   = w_n_last;
          w_valid  = 1'b1;
          if (r_last && (DELAY > 0)) begin
            // Next run's first address is already loaded; just hold it back.
            w_state = S_GAP;
            w_valid = 1'b0;
            w_gap   = GW'(DELAY - 1);
          end
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_state = S_RUN;
          w_valid = 1'b1;
        end else begin
          w_gap = r_gap - 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
        w_busy  = 1'b0;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_tmax   <= '0;
      r_mode   <= '0;
      r_t      <= '0;
      r_i      <= '0;
      r_c      <= '0;
      r_gap    <= '0;
      r_addr_d <= '0;
      r_addr_x <= '0;
      r_zero   <= 1'b0;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (en) begin
      r_state  <= w_state;
      r_tmax   <= w_tmax;
      r_mode   <= w_mode;
      r_t      <= w_t;
      r_i      <= w_i;
      r_c      <= w_c;
      r_gap    <= w_gap;
      r_addr_d <= w_addr_d;
      r_addr_x <= w_addr_x;
      r_zero   <= w_zero;
      r_last   <= w_last;
      r_valid  <= w_valid;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  // Strobes are masked while stalled; the held registers present the same
  // address again once en returns, so nothing is lost or duplicated.
  assign o_addr_d = r_addr_d;
  assign o_addr_x = r_addr_x;
  assign o_valid  = r_valid & en;
  assign o_zero   = r_zero & r_valid & en;
  assign o_last   = r_last & r_valid & en;
  assign o_busy   = r_busy;
  assign o_done   = r_done & en;
  assign o_state  = r_state;

endmodule

// File: tb/tb_addr_gen_upd_param.sv
module tb_addr_gen_upd_param;
  localparam int AW = 12;
  localparam int TW = 4;
  localparam int NC_A = 2, NI_A = 3, DL_A = 1;
  localparam int NC_B = 3, NI_B = 2, DL_B = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic i_start = 1'b0;
  logic [1:0] i_mode = 2'd0;
  logic [TW-1:0] i_ts = '0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] d_a, x_a, d_b, x_b;
  logic v_a, z_a, l_a, bz_a, dn_a, v_b, z_b, l_b, bz_b, dn_b;
  logic [1:0] st_a, st_b;

  addr_gen_upd_param #(.ADDR_WIDTH(AW), .TS_WIDTH(TW), .MAX_TIMESTEP(15),
    .NUM_CELL(NC_A), .NUM_INPUT(NI_A), .DELAY(DL_A)) u_a (
    .clk(clk), .rst(rst), .en(en), .i_start(i_start), .i_mode(i_mode),
    .i_timestep(i_ts), .o_addr_d(d_a), .o_addr_x(x_a), .o_valid(v_a),
    .o_zero(z_a), .o_last(l_a), .o_busy(bz_a), .o_done(dn_a), .o_state(st_a));

  addr_gen_upd_param #(.ADDR_WIDTH(AW), .TS_WIDTH(TW), .MAX_TIMESTEP(15),
    .NUM_CELL(NC_B), .NUM_INPUT(NI_B), .DELAY(DL_B)) u_b (
    .clk(clk), .rst(rst), .en(en), .i_start(i_start), .i_mode(i_mode),
    .i_timestep(i_ts), .o_addr_d(d_b), .o_addr_x(x_b), .o_valid(v_b),
    .o_zero(z_b), .o_last(l_b), .o_busy(bz_b), .o_done(dn_b), .o_state(st_b));

  // scoreboard
  logic [AW+AW+1:0] exp_a[$];
  logic [AW+AW+1:0] exp_b[$];
  int done_a = -1;
  int done_b = -1;
  bit bchk_a = 1'b0;
  bit bchk_b = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [AW+AW+1:0] pk(input int d, input int x, input bit z, input bit l);
    return {AW'(d), AW'(x), z, l};
  endfunction

  // monitor: pops one expectation per valid cycle, checks done timing
  always @(negedge clk) begin
    logic [AW+AW+1:0] e;
    if (bchk_a) begin check("busy_fall_a", 32'(bz_a), 0); bchk_a = 1'b0; end
    if (bchk_b) begin check("busy_fall_b", 32'(bz_b), 0); bchk_b = 1'b0; end
    if (v_a) begin
      if (exp_a.size() == 0) check("extra_valid_a", 1, 0);
      else begin e = exp_a.pop_front(); check("addr_a", 32'({d_a, x_a, z_a, l_a}), 32'(e)); end
    end
    if (v_b) begin
      if (exp_b.size() == 0) check("extra_valid_b", 1, 0);
      else begin e = exp_b.pop_front(); check("addr_b", 32'({d_b, x_b, z_b, l_b}), 32'(e)); end
    end
    if (dn_a) begin
      check("done_cycle_a", cyc + 1, done_a);
      check("done_pending_a", exp_a.size(), 0);
      check("busy_at_done_a", 32'(bz_a), 1);
      done_a = -1; bchk_a = 1'b1;
    end
    if (dn_b) begin
      check("done_cycle_b", cyc + 1, done_b);
      check("done_pending_b", exp_b.size(), 0);
      check("busy_at_done_b", 32'(bz_b), 1);
      done_b = -1; bchk_b = 1'b1;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input int mode, input int ts, output int k);
    i_start = 1'b1; i_mode = 2'(mode); i_ts = TW'(ts);
    tick();
    k = cyc;
    i_start = 1'b0;
  endtask

  // Hand-computed X sequence for NUM_CELL=2, NUM_INPUT=3, T=2, DELAY=1.
  task automatic push_xa(input int k);
    int td[12] = '{0, 2, 0, 2, 0, 2, 1, 3, 1, 3, 1, 3};
    int tx[12] = '{0, 3, 1, 4, 2, 5, 0, 3, 1, 4, 2, 5};
    for (int n = 0; n < 12; n++) exp_a.push_back(pk(td[n], tx[n], 1'b0, n[0]));
    done_a = k + 18;
  endtask

  task automatic push_model(input bit to_b, input int mode, input int tn, input int k);
    int nc, ni, dl, nin, r, d, x;
    bit z, l;
    nc = to_b ? NC_B : NC_A;
    ni = to_b ? NI_B : NI_A;
    dl = to_b ? DL_B : DL_A;
    nin = (mode == 0) ? ni : ((mode == 1) ? nc : 1);
    for (int c = 0; c < nc; c++)
      for (int i = 0; i < nin; i++)
        for (int t = 0; t < tn; t++) begin
          d = t * nc + c;
          if (mode == 0) x = t * ni + i;
          else if (mode == 1 && t > 0) x = (t - 1) * nc + i;
          else x = 0;
          z = (mode == 1) && (t == 0);
          l = (t == tn - 1);
          if (to_b) exp_b.push_back(pk(d, x, z, l));
          else exp_a.push_back(pk(d, x, z, l));
        end
    r = nc * nin;
    if (to_b) done_b = k + 1 + r * tn + (r - 1) * dl;
    else done_a = k + 1 + r * tn + (r - 1) * dl;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bz_a || bz_b) && n < 600) begin tick(); n++; end
    if (n >= 600) check({"timeout_", tag}, 1, 0);
    tick(); tick();
    check({"left_a_", tag}, exp_a.size(), 0);
    check({"left_b_", tag}, exp_b.size(), 0);
    check({"done_seen_a_", tag}, done_a, -1);
    check({"done_seen_b_", tag}, done_b, -1);
  endtask

  task automatic check_zero(input string tag);
    check({"rst_a_", tag}, 32'({d_a, x_a, v_a, z_a, l_a, bz_a, dn_a, st_a}), 0);
    check({"rst_b_", tag}, 32'({d_b, x_b, v_b, z_b, l_b, bz_b, dn_b, st_b}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [AW-1:0] hd_a, hx_a;
    // reset state
    rst = 1'b0;
    tick(); tick();
    check_zero("init");
    rst = 1'b1;
    tick();

    // X mode, T=2
    start(0, 2, k); push_xa(k); push_model(1'b1, 0, 2, k);
    wait_idle("x2");
    // H mode, T=3
    start(1, 3, k); push_model(1'b0, 1, 3, k); push_model(1'b1, 1, 3, k);
    wait_idle("h3");
    // bias mode, T=4
    start(2, 4, k); push_model(1'b0, 2, 4, k); push_model(1'b1, 2, 4, k);
    wait_idle("b4");
    // X mode, T=1: every address is the last of its run
    start(0, 1, k); push_model(1'b0, 0, 1, k); push_model(1'b1, 0, 1, k);
    wait_idle("x1");
    // bias mode, T=MAX_TIMESTEP
    start(2, 15, k); push_model(1'b0, 2, 15, k); push_model(1'b1, 2, 15, k);
    wait_idle("b15");

    // illegal starts
    start(0, 0, k);
    check("ts0_busy_a", 32'(bz_a), 0); check("ts0_busy_b", 32'(bz_b), 0);
    start(3, 2, k);
    check("mode3_busy_a", 32'(bz_a), 0); check("mode3_state_b", 32'(st_b), 0);
    tick(); tick();

    // start while busy is ignored
    start(0, 2, k); push_xa(k); push_model(1'b1, 0, 2, k);
    tick(); tick(); tick();
    i_start = 1'b1; i_mode = 2'd2; i_ts = 4'd5;
    tick();
    i_start = 1'b0; i_mode = 2'd3; i_ts = 4'd0;
    wait_idle("busy_start");

    // stall for 3 cycles mid-run
    start(0, 2, k); push_xa(k); push_model(1'b1, 0, 2, k);
    tick(); tick(); tick(); tick();
    en = 1'b0;
    hd_a = d_a; hx_a = x_a;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_valid", 32'({v_a, v_b, l_a, z_b}), 0);
      check("stall_hold_a", 32'({d_a, x_a}), 32'({hd_a, hx_a}));
    end
    done_a = done_a + 3; done_b = done_b + 3;
    en = 1'b1;
    wait_idle("stall");

    // reset mid-run aborts without done
    start(1, 3, k); push_model(1'b0, 1, 3, k); push_model(1'b1, 1, 3, k);
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    tick();
    exp_a.delete(); exp_b.delete(); done_a = -1; done_b = -1;
    check_zero("mid");
    tick();
    rst = 1'b1;
    for (int s = 0; s < 6; s++) tick();
    check("post_rst_idle", 32'({bz_a, bz_b, st_a, st_b}), 0);
    // fresh start reproduces the full sequence
    start(0, 2, k); push_xa(k); push_model(1'b1, 0, 2, k);
    wait_idle("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/addr_gen_upd_param.md
# addr_gen_upd_param

Parametrised read-address generator for the LSTM update-parameter stage. It walks the stored gate-delta buffer (d) and the matching operand buffer (X inputs, previous hidden state H, or none for bias) so the MAC array can accumulate dW, dU and db over all timesteps. It adds three things over the fixed-size generator: timestep count set at run time, selectable X/H/bias mode, and a start/busy/done handshake. Valid, last-of-run and zero-operand flags travel with each address.

## Interface
- ADDR_WIDTH, 12: width of both address outputs.
- TS_WIDTH, 4: width of i_timestep.
- MAX_TIMESTEP, 15: largest legal i_timestep.
- NUM_CELL, 8: LSTM cells; stride of the d and H buffers per timestep.
- NUM_INPUT, 8: input features; stride of the X buffer per timestep.
- DELAY, 1: idle cycles between runs (0 is legal).
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset.
- en  input  1  stall control; 0 freezes all state.
- i_start  input  1  start request, sampled only in IDLE.
- i_mode  input  2  0 = X (dW), 1 = H (dU), 2 = bias (db), 3 = reserved.
- i_timestep  input  TS_WIDTH  timesteps T, latched on start.
- o_addr_d  output  ADDR_WIDTH  gate-delta read address.
- o_addr_x  output  ADDR_WIDTH  X/H read address.
- o_valid  output  1  address pair valid this cycle.
- o_zero  output  1  operand is the implicit h[-1] = 0; consumer substitutes zero.
- o_last  output  1  final timestep of the current accumulation run.
- o_busy  output  1  sequence in progress.
- o_done  output  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, GAP, DONE. All outputs are registered. While rst = 0, all outputs and state are 0 and the FSM is in IDLE.
- **IDLE → RUN**
  - Condition: en = 1, i_start = 1, i_timestep in 1..MAX_TIMESTEP, and i_mode != 3.
  - Action: latch T and mode, then set o_busy = 1.
  - Any other start request is ignored, with no flag raised.
- **Operand count per cell:** n_in = NUM_INPUT (X), NUM_CELL (H), or 1 (bias).
- **Loop order:** cell c, outer (0..NUM_CELL-1); operand i, middle (0..n_in-1); timestep t, inner (0..T-1). Each (c, i) pair is one run.
- **Addresses per valid cycle:**
  - o_addr_d = t*NUM_CELL + c.
  - X mode: o_addr_x = t*NUM_INPUT + i.
  - H mode: o_addr_x = (t-1)*NUM_CELL + i for t ≥ 1. At t = 0, o_addr_x = 0 and o_zero = 1.
  - Bias mode: o_addr_x = 0 and o_zero = 0.
- Addresses are produced by stride additions on base registers, with no multipliers. They wrap modulo 2^ADDR_WIDTH. Choose parameters so that MAX_TIMESTEP*max(NUM_CELL, NUM_INPUT) ≤ 2^ADDR_WIDTH.
- o_last = 1 when t = T-1.
- **RUN → GAP:** after o_last, if the run was not the final run and DELAY > 0. In GAP, o_valid = 0 for DELAY cycles, then return to RUN.
  - If DELAY = 0, the next run follows back-to-back.
- **RUN → DONE:** after o_last of the final run. In DONE, o_done = 1 and o_valid = 0. In the following cycle the FSM enters IDLE and o_busy = 0.
- **Stall:** en = 0 holds all counters, addresses and state. o_valid, o_last, o_zero and o_done are forced to 0 during the stall and resume on the next en = 1 cycle with no address lost or repeated.
- Changes to i_mode or i_timestep mid-sequence have no effect. A new i_start during busy is ignored.
- Reset asserted mid-sequence aborts on that clock edge; no o_done is produced.

## Timing
- Start accepted at edge k → first valid address at cycle k+1.
- R = NUM_CELL*n_in runs. Valid cycles = R*T.
- o_done is high at cycle k+1+R*T+(R-1)*DELAY, plus any stalled cycles.
- o_busy rises at k+1 and falls one cycle after o_done.
- A new start is accepted at the earliest in the first IDLE cycle after o_done.

## Test plan
- **X mode:** NUM_CELL=2, NUM_INPUT=3, T=2, DELAY=1.
  - Required (d,x) sequence: (0,0),(2,3), gap, (0,1),(2,4), gap, (0,2),(2,5), gap, (1,0),(3,3), …, (1,2),(3,5).
  - o_last on every second valid; o_done at k+1+6*2+5 = k+18.
- **H mode:** NUM_CELL=2, T=3, DELAY=0.
  - Run c=0,i=0: d = 0,2,4; x = 0 with o_zero=1, then 0, then 2.
  - Run c=0,i=1: x = 0 (o_zero), 1, 3. Total of 12 valid cycles with no gaps.
- **Bias mode:** NUM_CELL=3, T=4. Required: d = 0,3,6,9 / 1,4,7,10 / 2,5,8,11; x = 0 throughout; o_zero = 0.
- **Stall:** drop en for 3 cycles in the middle of the X-mode run above.
  - Required: outputs frozen with o_valid = 0; sequence resumes unchanged; o_done delayed by exactly 3 cycles.
- **Illegal starts:**
  - i_timestep = 0 → ignored.
  - i_mode = 3 → ignored.
  - i_start while busy → ignored; the original sequence is unaffected.
- **Reset:** rst = 0 mid-run → next cycle all outputs are 0 and the FSM is in IDLE, with no o_done. A fresh start afterwards reproduces the full sequence from (0,0).
